isp_loader: RTL

In-system programming loader that sits directly upstream of the core's ISP and boot ports. It accepts a framed byte stream, assembles little-endian 32-bit words and writes them into instruction memory through `isp_address`/`isp_data`/`isp_write`. It holds the core in reset while loading, verifies a checksum, then releases the core and pulses `start` with the entry PC on `prog_address`.

---
 rtl/isp_loader_pkg.sv | 25 ++
 rtl/isp_loader_byte_packer.sv | 51 +++++
 rtl/isp_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/isp_loader_pkg.sv
// Shared definitions for the ISP loader: FSM state codes, frame header
// value and the byte-index width used by the word packer.
package isp_loader_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_ENTRY = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_RUN   = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  // Frame header byte
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Byte index inside a 32-bit word
  localparam int BIDX_W = 2;

  // A frame is in progress in every state except the three resting ones
  function automatic logic state_is_busy(input logic [2:0] st);
    return !((st == ST_IDLE) || (st == ST_RUN) || (st == ST_ERROR));
  endfunction

endpackage

// File: rtl/isp_loader_byte_packer.sv
// Collects four stream bytes into a little-endian 32-bit word. The
// completed word is presented combinationally together with a one-cycle
// word_done_o on the cycle the fourth byte is taken.
module isp_byte_packer
  import isp_loader_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [BIDX_W-1:0] idx_q, idx_d;
  logic [23:0]       low_q, low_d;

  // Next byte slot and low-byte shadow; clear drops any partial word
  always_comb begin
    idx_d = idx_q;
    low_d = low_q;
    if (clear_i) begin
      idx_d = '0;
      low_d = '0;
    end else if (byte_valid_i) begin
      idx_d = idx_q + 1'b1;
      case (idx_q)
        2'd0:    low_d[7:0]   = byte_i;
        2'd1:    low_d[15:8]  = byte_i;
        2'd2:    low_d[23:16] = byte_i;
        default: low_d        = low_q;
      endcase
    end
  end

  // Byte index and low bytes registers
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      idx_q <= '0;
      low_q <= '0;
    end else begin
      idx_q <= idx_d;
      low_q <= low_d;
    end
  end

  assign word_o      = {byte_i, low_q};
  assign word_done_o = byte_valid_i && !clear_i && (idx_q == '1);

endmodule

// File: rtl/isp_loader.sv
// In-system programming loader. Parses SYNC / count / entry PC / words /
// checksum frames, writes words to instruction memory, holds the core in
// reset while loading and boots it when the checksum matches.
//
// Stream handshake: a byte transfers on a rising clock edge where
// byte_valid && byte_ready. byte_ready is registered; it is held low for
// the cycle after a word's last byte (the write cycle) and after the
// checksum byte, otherwise high whenever out of reset.
module isp_loader
  import isp_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic [ADDRESS_BITS-1:0] isp_address,
  output logic [DATA_WIDTH-1:0]   isp_data,
  output logic                    isp_write,
  output logic                    core_reset,
  output logic                    start,
  output logic [ADDRESS_BITS-1:0] prog_address,
  output logic                    busy,
  output logic                    error
);

  localparam int         CW        = ADDRESS_BITS + 1;
  localparam logic [15:0] MAX_WORDS = 16'(1 << ADDRESS_BITS);

  logic [2:0]              state_q, state_d;
  logic                    ready_q;
  logic                    cnt_phase_q;
  logic [7:0]              cnt_lo_q;
  logic [CW-1:0]           words_left_q;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    wr_q;
  logic [ADDRESS_BITS-1:0] prog_q;
  logic [7:0]              xor_q;
  logic                    boot_q;
  logic                    start_q;

  logic        accept;
  logic        is_sync;
  logic        hdr_accept;
  logic        pk_valid;
  logic [31:0] pk_word;
  logic        pk_done;
  logic [15:0] count_word;
  logic        csum_ok;

  assign accept     = byte_valid && ready_q;
  assign is_sync    = (byte_in == SYNC_BYTE);
  // SYNC only restarts from the resting states; inside a frame it is payload
  assign hdr_accept = accept && is_sync &&
                      ((state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_ERROR));
  assign pk_valid   = accept && ((state_q == ST_ENTRY) || (state_q == ST_DATA));
  assign count_word = {byte_in, cnt_lo_q};
  assign csum_ok    = (byte_in == xor_q);

  isp_byte_packer u_packer (
    .clock_i      (clock),
    .reset_ni     (reset),
    .clear_i      (hdr_accept),
    .byte_valid_i (pk_valid),
    .byte_i       (byte_in),
    .word_o       (pk_word),
    .word_done_o  (pk_done)
  );

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (hdr_accept) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (accept && cnt_phase_q) begin
          if (count_word > MAX_WORDS) state_d = ST_ERROR;
          else                        state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (pk_done) state_d = (words_left_q == '0) ? ST_CHECK : ST_DATA;
      end
      ST_DATA: begin
        if (pk_done && (words_left_q == CW'(1))) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (accept) state_d = csum_ok ? ST_RUN : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    core_reset = (state_q != ST_RUN);
    busy       = state_is_busy(state_q);
    error      = (state_q == ST_ERROR);
  end

  // Datapath: handshake, count capture, word write, XOR and boot sequencing
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_q      <= 1'b0;
      cnt_phase_q  <= 1'b0;
      cnt_lo_q     <= '0;
      words_left_q <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      prog_q       <= '0;
      xor_q        <= '0;
      boot_q       <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      ready_q <= !(accept && (((state_q == ST_DATA) && pk_done) || (state_q == ST_CHECK)));
      wr_q    <= (state_q == ST_DATA) && pk_done;
      boot_q  <= accept && (state_q == ST_CHECK) && csum_ok;
      start_q <= boot_q;

      if (wr_q) addr_q <= addr_q + ADDRESS_BITS'(1);

      if (accept && ((state_q == ST_COUNT) || (state_q == ST_ENTRY) || (state_q == ST_DATA)))
        xor_q <= xor_q ^ byte_in;

      if (accept && (state_q == ST_COUNT)) begin
        if (!cnt_phase_q) begin
          cnt_lo_q    <= byte_in;
          cnt_phase_q <= 1'b1;
        end else begin
          words_left_q <= count_word[CW-1:0];
          cnt_phase_q  <= 1'b0;
        end
      end

      if (pk_done && (state_q == ST_ENTRY)) prog_q <= pk_word[ADDRESS_BITS-1:0];

      if (pk_done && (state_q == ST_DATA)) begin
        data_q       <= pk_word;
        words_left_q <= words_left_q - CW'(1);
      end

      if (hdr_accept) begin
        addr_q      <= '0;
        xor_q       <= '0;
        cnt_phase_q <= 1'b0;
      end
    end
  end

  assign byte_ready   = ready_q;
  assign isp_address  = addr_q;
  assign isp_data     = data_q;
  assign isp_write    = wr_q;
  assign start        = start_q;
  assign prog_address = prog_q;

endmodule
